// File: rtl/fifo_burst_reader_pkg.sv
// fifo_burst_reader_pkg
//   Shared types for the FIFO burst reader: FSM state encoding, the per-beat
//   tag bits carried alongside data in the output buffer, and buffer depth.
package fifo_burst_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        PAD   = 2'd2
    } state_t;

    // Data-independent part of a buffered beat; the data field is added by a
    // WIDTH-parameterised typedef inside the modules.
    typedef struct packed {
        logic pad;
        logic last;
    } beat_tag_t;

    localparam int OBUF_DEPTH = 2;

endpackage

// File: rtl/fifo_burst_reader_obuf.sv
// fifo_burst_reader_obuf
//   Two-entry output buffer between the burst FSM and the valid/ready stream.
//   Ports:
//     clk, rst    clock, asynchronous active-high reset
//     push        write push_data (ignored when full)
//     push_data   entry to store
//     pop         remove head entry (ignored when empty)
//     head        current head entry
//     count       number of stored entries, 0..2
module fifo_burst_reader_obuf
    import fifo_burst_reader_pkg::*;
#(
    parameter int ENTRY_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    output logic [ENTRY_W-1:0] head,
    output logic [1:0]         count
);

    logic [ENTRY_W-1:0] mem [OBUF_DEPTH];
    logic               wr_ptr;
    logic               rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign do_push = push && (count != 2'(OBUF_DEPTH));
    assign do_pop  = pop && (count != 2'd0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
//   Drains a show-ahead FIFO and re-emits its words as fixed BURST_LEN-beat
//   bursts on a valid/ready stream. A burst starved for TIMEOUT empty cycles
//   is completed with zero pad beats.
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     fifo_empty        FIFO empty flag
//     fifo_rd_data      FIFO head word, sampled when fifo_rd_en=1
//     fifo_rd_en        FIFO read strobe
//     m_valid/m_ready   output stream handshake
//     m_data            beat data (0 on pad beats)
//     m_last            final beat of a burst
//     m_pad             pad beat
//     busy              FSM not idle
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rd_data,
    output logic             fifo_rd_en,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             m_pad,
    output logic             busy
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        beat_tag_t        tag;
    } entry_t;

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int EW = $clog2(TIMEOUT + 1);

    state_t          state, state_nxt;
    logic [BW-1:0]   beat_cnt, beat_cnt_nxt;
    logic [EW-1:0]   empty_cnt, empty_cnt_nxt;
    logic [1:0]      ob_count;
    logic            ob_room;
    logic            push;
    logic            is_last;
    entry_t          push_e;
    entry_t          head_e;

    // Room is judged on the registered count only, so m_ready never reaches
    // fifo_rd_en combinationally.
    assign ob_room = ob_count < 2'(OBUF_DEPTH);
    assign is_last = beat_cnt == BW'(BURST_LEN - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            empty_cnt <= '0;
        end else begin
            state     <= state_nxt;
            beat_cnt  <= beat_cnt_nxt;
            empty_cnt <= empty_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        beat_cnt_nxt  = beat_cnt;
        empty_cnt_nxt = empty_cnt;
        fifo_rd_en    = 1'b0;
        push          = 1'b0;
        push_e        = '0;

        case (state)
            IDLE: begin
                if (!fifo_empty)
                    state_nxt = BURST;
            end
            BURST: begin
                if (!fifo_empty && ob_room) begin
                    fifo_rd_en      = 1'b1;
                    push            = 1'b1;
                    push_e.data     = fifo_rd_data;
                    push_e.tag.last = is_last;
                    empty_cnt_nxt   = '0;
                end else if (fifo_empty) begin
                    if (empty_cnt != EW'(TIMEOUT))
                        empty_cnt_nxt = empty_cnt + 1'b1;
                    if (empty_cnt_nxt == EW'(TIMEOUT))
                        state_nxt = PAD;
                end
            end
            PAD: begin
                if (ob_room) begin
                    push            = 1'b1;
                    push_e.tag.pad  = 1'b1;
                    push_e.tag.last = is_last;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Closing push ends the burst; a new one can start only from IDLE.
        if (push) begin
            if (is_last) begin
                beat_cnt_nxt  = '0;
                empty_cnt_nxt = '0;
                state_nxt     = IDLE;
            end else begin
                beat_cnt_nxt = beat_cnt + 1'b1;
            end
        end
    end

    fifo_burst_reader_obuf #(
        .ENTRY_W($bits(entry_t))
    ) u_obuf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_e),
        .pop       (m_ready),
        .head      (head_e),
        .count     (ob_count)
    );

    assign m_valid = ob_count != 2'd0;
    assign m_data  = head_e.data;
    assign m_pad   = head_e.tag.pad;
    assign m_last  = head_e.tag.last;
    assign busy    = state != IDLE;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader
//   Drives fifo_burst_reader from a queue-modelled show-ahead FIFO and checks
//   the output stream against a stream-level reference: every word read is
//   expected in order; a burst starved for TIMEOUT empty cycles is expected
//   to be completed with zero pad beats; last falls on every BURST_LEN-th beat.
module tb_fifo_burst_reader;

    localparam int W  = 8;
    localparam int BL = 4;
    localparam int TO = 16;

    typedef struct packed {
        logic [W-1:0] d;
        logic         pad;
        logic         last;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         fifo_empty;
    logic [W-1:0] fifo_rd_data;
    logic         fifo_rd_en;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic         m_last;
    logic         m_pad;
    logic         busy;

    fifo_burst_reader #(.WIDTH(W), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .m_pad        (m_pad),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    logic [W-1:0] fq[$];
    beat_t        expq[$];
    int           rpos, empty_run, data_in_buf, pad_seen;
    int           n_chk, n_fail;
    int           rdy_mode;
    bit           rd_seen, prev_stall;
    beat_t        prev_beat;
    logic         s_busy, s_rd, s_valid, s_pad, s_acc;
    logic [W-1:0] s_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic refresh();
        fifo_empty   = (fq.size() == 0);
        fifo_rd_data = (fq.size() != 0) ? fq[0] : W'($urandom);
    endtask

    task automatic load(input logic [W-1:0] w);
        fq.push_back(w);
        refresh();
    endtask

    task automatic model_clear();
        fq.delete();
        expq.delete();
        rpos        = 0;
        empty_run   = 0;
        data_in_buf = 0;
        prev_stall  = 0;
        rd_seen     = 0;
    endtask

    task automatic monitor();
        beat_t e;
        rd_seen = 0;
        s_busy  = busy;
        s_rd    = fifo_rd_en;
        s_valid = m_valid;
        s_pad   = m_pad;
        s_data  = m_data;
        s_acc   = m_valid && m_ready;
        if (rst) return;
        if (prev_stall) begin
            check("hold_valid", 32'(m_valid), 32'd1);
            check("hold_beat", 32'({m_data, m_pad, m_last}), 32'(prev_beat));
        end
        if (fifo_rd_en) begin
            check("rd_while_empty", 32'(fifo_empty), 32'd0);
            check("rd_while_full", 32'(data_in_buf >= 2), 32'd0);
            if (!fifo_empty) begin
                e.d = fq[0]; e.pad = 1'b0; e.last = (rpos == BL - 1);
                expq.push_back(e);
                rpos = (rpos + 1) % BL;
                empty_run = 0;
                data_in_buf++;
                rd_seen = 1;
            end
        end else if (fifo_empty && rpos != 0) begin
            empty_run++;
            if (empty_run == TO) begin
                while (rpos != 0) begin
                    e.d = '0; e.pad = 1'b1; e.last = (rpos == BL - 1);
                    expq.push_back(e);
                    rpos = (rpos + 1) % BL;
                end
                empty_run = 0;
            end
        end
        if (m_valid && m_ready) begin
            check("beat_expected", 32'(expq.size() > 0), 32'd1);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("beat", 32'({m_data, m_pad, m_last}), 32'(e));
                if (!e.pad) data_in_buf--;
            end
            if (m_pad) pad_seen++;
        end
        prev_stall = m_valid && !m_ready;
        prev_beat  = {m_data, m_pad, m_last};
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (rd_seen) void'(fq.pop_front());
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = !m_ready;
            default: m_ready = ($urandom_range(0, 3) != 0);
        endcase
        refresh();
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        cycle();
        while ((fq.size() != 0 || expq.size() != 0 || s_busy) && n < budget) begin
            cycle();
            n++;
        end
        check(tag, 32'(fq.size() + expq.size()), 32'd0);
        check({tag, "_idle"}, 32'(s_busy), 32'd0);
    endtask

    initial begin
        int first_pad, busy_fall, pads0, acc, n;
        n_chk = 0; n_fail = 0; pad_seen = 0; rdy_mode = 0;
        rst = 1'b1; m_ready = 1'b1;
        model_clear();
        refresh();

        // reset state
        @(negedge clk);
        check("reset_outs", 32'({fifo_rd_en, m_valid, m_data, m_last, m_pad, busy}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        cycle(); cycle();

        // two back-to-back bursts with entry latency
        for (int i = 0; i < 8; i++) load(W'(8'h10 + i));
        cycle();
        check("t0_busy", 32'(s_busy), 32'd0);
        check("t0_rd", 32'(s_rd), 32'd0);
        cycle();
        check("t1_busy", 32'(s_busy), 32'd1);
        check("t1_rd", 32'(s_rd), 32'd1);
        check("t1_valid", 32'(s_valid), 32'd0);
        cycle();
        check("t2_valid", 32'(s_valid), 32'd1);
        check("t2_data", 32'(s_data), 32'h10);
        pads0 = pad_seen;
        drain("bursts8", 100);
        check("bursts8_nopad", 32'(pad_seen - pads0), 32'd0);

        // starved burst gets padded after TIMEOUT empty cycles
        pads0 = pad_seen; first_pad = -1; busy_fall = -1;
        load(8'hA0); load(8'hA1);
        for (int k = 0; k < 30; k++) begin
            cycle();
            if (s_acc && s_pad && first_pad < 0) first_pad = k;
            if (k > 1 && !s_busy && busy_fall < 0) busy_fall = k;
        end
        check("pad_first_at", 32'(first_pad), 32'd20);
        check("pad_busy_fall", 32'(busy_fall), 32'd21);
        check("pad_count", 32'(pad_seen - pads0), 32'd2);
        drain("pad_drain", 50);

        // toggling m_ready: hold and full-buffer checks run in the monitor
        rdy_mode = 1;
        for (int i = 0; i < 4; i++) load(W'(i));
        drain("toggle", 100);
        rdy_mode = 0;

        // 15 empty cycles then data: no padding
        pads0 = pad_seen;
        load(8'h30); load(8'h31);
        for (int k = 0; k < 18; k++) cycle();
        load(8'h55); load(8'h56);
        drain("t15", 60);
        check("t15_nopad", 32'(pad_seen - pads0), 32'd0);

        // reset in the middle of a burst
        for (int i = 0; i < 4; i++) load(W'(8'h60 + i));
        acc = 0; n = 0;
        while (acc < 2 && n < 20) begin
            cycle();
            if (s_acc) acc++;
            n++;
        end
        check("mid_beats", 32'(acc), 32'd2);
        rst = 1'b1;
        #1;
        check("rst_async", 32'({fifo_rd_en, m_valid, m_data, m_last, m_pad, busy}), 32'd0);
        model_clear();
        refresh();
        cycle();
        check("rst_held", 32'({s_busy, s_valid, s_rd}), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) load(W'(8'h70 + i));
        drain("post_rst", 60);

        // random traffic and stalls
        rdy_mode = 2;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 99) < 3) begin
                for (int k = 0; k < $urandom_range(10, 25); k++) cycle();
            end else if ($urandom_range(0, 3) == 0) begin
                for (int k = 0; k < $urandom_range(1, 3); k++) load(W'($urandom));
            end
            cycle();
        end
        drain("random", 400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
